// File: rtl/pwr_supv_pkg.sv
// Shared types and constants for the 3.3 V rail power-good supervisor.
package pwr_supv_pkg;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RAMP   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_TIMEOUT  = 2'd1;
  localparam logic [1:0] FC_BROWNOUT = 2'd2;

  // Regulator is enabled in every state that is trying to bring or keep the rail up.
  function automatic logic rail_on(state_t s);
    return (s == S_RAMP) || (s == S_SETTLE) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/pg_debounce.sv
// Two-flop synchronizer for the asynchronous power-good comparator, followed by
// a run-length filter: PG_DB follows only after DEBOUNCE consecutive disagreeing cycles.
module pg_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PG_RAW,
  output logic PG_DB
);

  localparam int unsigned RW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [RW-1:0] RUN_LAST = RW'(DEBOUNCE - 1);

  logic          pg_m;
  logic          pg_s;
  logic [RW-1:0] run;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pg_m  <= 1'b0;
      pg_s  <= 1'b0;
      run   <= '0;
      PG_DB <= 1'b0;
    end else begin
      pg_m <= PG_RAW;
      pg_s <= pg_m;
      if (pg_s == PG_DB) begin
        run <= '0;
      end else if (run == RUN_LAST) begin
        PG_DB <= pg_s;
        run   <= '0;
      end else begin
        run <= run + RW'(1);
      end
    end
  end

endmodule

// File: rtl/pwr_good_supervisor.sv
// Sequences the regulator enable, holds board reset until power-good has been
// stable for HOLDOFF cycles, and latches ramp-timeout / brown-out faults.
module pwr_good_supervisor #(
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned RAMP_TIMEOUT = 1000,
  parameter int unsigned HOLDOFF      = 200,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE_REQ,
  input  logic       PG_RAW,
  output logic       REG_EN,
  output logic       SYS_RESET,
  output logic       PWR_OK,
  output logic       FAULT,
  output logic [1:0] FAULT_CODE
);
  import pwr_supv_pkg::*;

  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       fc_nx;
  logic             fault_nx;
  logic             pg_db;

  pg_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
    .CLK   (CLK),
    .RESET (RESET),
    .PG_RAW(PG_RAW),
    .PG_DB (pg_db)
  );

  // Fault latch and code persist through FAULT -> OFF; only a new request clears them.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fc_nx    = FAULT_CODE;
    fault_nx = FAULT;
    case (state)
      S_OFF: begin
        if (ENABLE_REQ) begin
          state_nx = S_RAMP;
          cnt_nx   = '0;
          fc_nx    = FC_NONE;
          fault_nx = 1'b0;
        end
      end
      S_RAMP: begin
        if (!ENABLE_REQ) begin
          state_nx = S_OFF;
          cnt_nx   = '0;
        end else if (pg_db) begin
          state_nx = S_SETTLE;
          cnt_nx   = '0;
        end else if (cnt == RAMP_LAST) begin
          state_nx = S_FAULT;
          cnt_nx   = '0;
          fc_nx    = FC_TIMEOUT;
          fault_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (!ENABLE_REQ) begin
          state_nx = S_OFF;
          cnt_nx   = '0;
        end else if (!pg_db) begin
          state_nx = S_RAMP;
          cnt_nx   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!ENABLE_REQ) begin
          state_nx = S_OFF;
          cnt_nx   = '0;
        end else if (!pg_db) begin
          state_nx = S_FAULT;
          cnt_nx   = '0;
          fc_nx    = FC_BROWNOUT;
          fault_nx = 1'b1;
        end
      end
      S_FAULT: begin
        if (!ENABLE_REQ) begin
          state_nx = S_OFF;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_OFF;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_OFF;
      cnt        <= '0;
      REG_EN     <= 1'b0;
      SYS_RESET  <= 1'b1;
      PWR_OK     <= 1'b0;
      FAULT      <= 1'b0;
      FAULT_CODE <= FC_NONE;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      REG_EN     <= rail_on(state_nx);
      SYS_RESET  <= (state_nx != S_RUN);
      PWR_OK     <= (state_nx == S_RUN);
      FAULT      <= fault_nx;
      FAULT_CODE <= fc_nx;
    end
  end

endmodule

// File: tb/tb_pwr_good_supervisor.sv
// Directed bench for pwr_good_supervisor: cycle-level reference model compared
// every cycle, plus hand-computed timing expectations for each scenario.
module tb_pwr_good_supervisor;

  localparam int DEBOUNCE     = 4;
  localparam int RAMP_TIMEOUT = 20;
  localparam int HOLDOFF      = 10;

  localparam int MO_OFF = 0, MO_RAMP = 1, MO_SETTLE = 2, MO_RUN = 3, MO_FAULT = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ENABLE_REQ = 1'b0;
  logic       PG_RAW = 1'b0;
  logic       REG_EN, SYS_RESET, PWR_OK, FAULT;
  logic [1:0] FAULT_CODE;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mode  = MO_OFF;
  int m_n     = 0;
  int m_entry = 0;
  bit m_db    = 1'b0;
  bit m_raw1  = 1'b0;
  bit m_fault = 1'b0;
  int m_fc    = 0;
  bit ps_q[$];

  pwr_good_supervisor #(
    .DEBOUNCE    (DEBOUNCE),
    .RAMP_TIMEOUT(RAMP_TIMEOUT),
    .HOLDOFF     (HOLDOFF),
    .CNT_W       (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENABLE_REQ(ENABLE_REQ),
    .PG_RAW    (PG_RAW),
    .REG_EN    (REG_EN),
    .SYS_RESET (SYS_RESET),
    .PWR_OK    (PWR_OK),
    .FAULT     (FAULT),
    .FAULT_CODE(FAULT_CODE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_mode  = MO_OFF;
    m_entry = m_n;
    m_db    = 1'b0;
    m_raw1  = 1'b0;
    m_fault = 1'b0;
    m_fc    = 0;
    ps_q.delete();
  endtask

  // One clock edge: state rules use the filtered level from before the edge;
  // the filter flips once its last DEBOUNCE synchronized samples all disagree.
  task automatic model_step();
    bit en;
    bit flip;
    int el;
    en = ENABLE_REQ;
    m_n++;
    el = m_n - m_entry;
    case (m_mode)
      MO_OFF:    if (en) begin m_mode = MO_RAMP; m_entry = m_n; m_fault = 0; m_fc = 0; end
      MO_RAMP:   if (!en) m_mode = MO_OFF;
                 else if (m_db) begin m_mode = MO_SETTLE; m_entry = m_n; end
                 else if (el == RAMP_TIMEOUT) begin m_mode = MO_FAULT; m_fault = 1; m_fc = 1; end
      MO_SETTLE: if (!en) m_mode = MO_OFF;
                 else if (!m_db) begin m_mode = MO_RAMP; m_entry = m_n; end
                 else if (el == HOLDOFF) m_mode = MO_RUN;
      MO_RUN:    if (!en) m_mode = MO_OFF;
                 else if (!m_db) begin m_mode = MO_FAULT; m_fault = 1; m_fc = 2; end
      default:   if (!en) m_mode = MO_OFF;
    endcase
    flip = (ps_q.size() >= DEBOUNCE);
    if (flip)
      for (int i = 0; i < DEBOUNCE; i++)
        if (ps_q[ps_q.size() - 1 - i] == m_db) flip = 1'b0;
    if (flip) m_db = !m_db;
    ps_q.push_back(m_raw1);
    if (ps_q.size() > 16) void'(ps_q.pop_front());
    m_raw1 = PG_RAW;
  endtask

  initial begin
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) model_reset();
      else model_step();
    end
  end

  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("model_reg_en", int'(REG_EN),
          (m_mode == MO_RAMP || m_mode == MO_SETTLE || m_mode == MO_RUN) ? 1 : 0);
      chk("model_sys_reset", int'(SYS_RESET), (m_mode == MO_RUN) ? 0 : 1);
      chk("model_pwr_ok", int'(PWR_OK), (m_mode == MO_RUN) ? 1 : 0);
      chk("model_fault", int'(FAULT), int'(m_fault));
      chk("model_fault_code", int'(FAULT_CODE), m_fc);
    end
  end

  initial begin
    #1 RESET = 1'b1;
    repeat (3) tick();
    chk("rst_reg_en", int'(REG_EN), 0);
    chk("rst_sys_reset", int'(SYS_RESET), 1);
    chk("rst_pwr_ok", int'(PWR_OK), 0);
    chk("rst_fault", int'(FAULT), 0);
    chk("rst_fault_code", int'(FAULT_CODE), 0);
    RESET = 1'b0;

    // Normal power-up
    ENABLE_REQ = 1'b1;
    tick();
    chk("up_reg_en_1edge", int'(REG_EN), 1);
    repeat (4) tick();
    PG_RAW = 1'b1;
    repeat (16) tick();
    chk("up_sys_reset_16", int'(SYS_RESET), 1);
    chk("up_pwr_ok_16", int'(PWR_OK), 0);
    tick();
    chk("up_sys_reset_17", int'(SYS_RESET), 0);
    chk("up_pwr_ok_17", int'(PWR_OK), 1);

    // Three-cycle glitch on the comparator must be filtered out
    for (int i = 0; i < 13; i++) begin
      if (i == 0) PG_RAW = 1'b0;
      if (i == 3) PG_RAW = 1'b1;
      tick();
      chk("glitch_pwr_ok", int'(PWR_OK), 1);
      chk("glitch_fault", int'(FAULT), 0);
    end

    // Request drops on the cycle the filtered power-good is first seen low
    PG_RAW = 1'b0;
    repeat (6) tick();
    chk("simul_pwr_ok_pre", int'(PWR_OK), 1);
    ENABLE_REQ = 1'b0;
    tick();
    chk("simul_pwr_ok", int'(PWR_OK), 0);
    chk("simul_reg_en", int'(REG_EN), 0);
    chk("simul_fault", int'(FAULT), 0);
    chk("simul_fault_code", int'(FAULT_CODE), 0);

    // Ramp timeout
    repeat (2) tick();
    ENABLE_REQ = 1'b1;
    tick();
    chk("ramp_reg_en", int'(REG_EN), 1);
    repeat (19) tick();
    chk("ramp_fault_19", int'(FAULT), 0);
    tick();
    chk("ramp_fault_20", int'(FAULT), 1);
    chk("ramp_code_20", int'(FAULT_CODE), 1);
    chk("ramp_reg_en_20", int'(REG_EN), 0);
    repeat (5) tick();
    chk("ramp_fault_hold", int'(FAULT), 1);
    chk("ramp_reg_en_hold", int'(REG_EN), 0);
    ENABLE_REQ = 1'b0;
    tick();
    chk("ramp_off_code", int'(FAULT_CODE), 1);
    chk("ramp_off_fault", int'(FAULT), 1);
    ENABLE_REQ = 1'b1;
    tick();
    chk("ramp_retry_code", int'(FAULT_CODE), 0);
    chk("ramp_retry_fault", int'(FAULT), 0);
    chk("ramp_retry_reg_en", int'(REG_EN), 1);

    // Brown-out from RUN
    PG_RAW = 1'b1;
    repeat (17) tick();
    chk("bo_run_pwr_ok", int'(PWR_OK), 1);
    PG_RAW = 1'b0;
    repeat (6) tick();
    chk("bo_fault_6", int'(FAULT), 0);
    chk("bo_pwr_ok_6", int'(PWR_OK), 1);
    tick();
    chk("bo_fault_7", int'(FAULT), 1);
    chk("bo_code_7", int'(FAULT_CODE), 2);
    chk("bo_sys_reset_7", int'(SYS_RESET), 1);
    chk("bo_reg_en_7", int'(REG_EN), 0);
    ENABLE_REQ = 1'b0;
    tick();
    chk("bo_off_code", int'(FAULT_CODE), 2);
    chk("bo_off_fault", int'(FAULT), 1);

    // Asynchronous reset in SETTLE, then full restart
    tick();
    ENABLE_REQ = 1'b1;
    PG_RAW = 1'b1;
    repeat (10) tick();
    chk("ar_settle_reg_en", int'(REG_EN), 1);
    chk("ar_settle_sys_reset", int'(SYS_RESET), 1);
    #2 RESET = 1'b1;
    #1;
    chk("ar_reg_en", int'(REG_EN), 0);
    chk("ar_sys_reset", int'(SYS_RESET), 1);
    chk("ar_pwr_ok", int'(PWR_OK), 0);
    chk("ar_fault", int'(FAULT), 0);
    chk("ar_fault_code", int'(FAULT_CODE), 0);
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk("ar_restart_reg_en", int'(REG_EN), 1);
    repeat (15) tick();
    chk("ar_restart_pwr_ok_16", int'(PWR_OK), 0);
    tick();
    chk("ar_restart_pwr_ok_17", int'(PWR_OK), 1);
    chk("ar_restart_sys_reset_17", int'(SYS_RESET), 0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwr_good_supervisor.md
Name: pwr_good_supervisor

Overview:
- Consumer-side companion to the board's 3.3 V LDO regulator model.
- Drives the regulator enable and watches the regulator's power-good comparator, which is asynchronous to CLK.
- Releases the board system reset only after power-good has been stable for a hold-off period.
- Latches ramp-timeout and brown-out faults for the slow-control readout.

Parameters:
- DEBOUNCE, 4: consecutive synchronized cycles required before the filtered power-good changes.
- RAMP_TIMEOUT, 1000: cycles allowed in RAMP for power-good to assert. Range 1..2^CNT_W-1.
- HOLDOFF, 200: cycles spent in SETTLE before reset release. Range 1..2^CNT_W-1.
- CNT_W, 16: width of the shared cycle counter.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE_REQ  input  1  slow-control request to power the rail. Synchronous to CLK.
- PG_RAW  input  1  regulator power-good comparator output. Asynchronous.
- REG_EN  output  1  regulator enable.
- SYS_RESET  output  1  board reset, active-high.
- PWR_OK  output  1  rail up and stable.
- FAULT  output  1  latched fault indicator.
- FAULT_CODE  output  2  0 = none, 1 = ramp timeout, 2 = brown-out. 3 is unused.

Behaviour:
- Reset: one clock; RESET is asynchronous and active-high.
  - While RESET is high: state = OFF, counter = 0, sync flops = 0, pg_db = 0.
  - Outputs during reset: REG_EN = 0, SYS_RESET = 1, PWR_OK = 0, FAULT = 0, FAULT_CODE = 0.
  - RESET asserted mid-operation forces all of the above immediately, without waiting for a CLK edge.
- Input filter (pg_s, pg_db):
  - PG_RAW passes through a 2-flop synchronizer, giving pg_s.
  - pg_db takes the value of pg_s on the edge after pg_s has differed from pg_db for DEBOUNCE consecutive cycles.
  - Any agreement between pg_s and pg_db clears the run count.
  - Latency from a clean PG_RAW edge to a pg_db change is 2 + DEBOUNCE edges.
- Outputs are registered and update on the same edge as the state register. No combinational paths from inputs to outputs.
- States and transitions:
  - OFF: REG_EN = 0, SYS_RESET = 1, PWR_OK = 0.
    - ENABLE_REQ = 1 → RAMP. Clear counter, FAULT_CODE and FAULT.
  - RAMP: REG_EN = 1, SYS_RESET = 1.
    - Priority order: ENABLE_REQ = 0 → OFF; else pg_db = 1 → SETTLE (counter cleared); else counter = RAMP_TIMEOUT-1 → FAULT with code 1; else increment counter.
  - SETTLE: REG_EN = 1, SYS_RESET = 1.
    - Priority order: ENABLE_REQ = 0 → OFF; else pg_db = 0 → RAMP (counter cleared; ramp timer restarts); else counter = HOLDOFF-1 → RUN; else increment counter.
  - RUN: REG_EN = 1, SYS_RESET = 0, PWR_OK = 1.
    - Priority order: ENABLE_REQ = 0 → OFF; else pg_db = 0 → FAULT with code 2.
    - If ENABLE_REQ falls in the same cycle as a pg_db fall, OFF wins and no fault is recorded.
  - FAULT: REG_EN = 0, SYS_RESET = 1, PWR_OK = 0, FAULT = 1. FAULT_CODE holds.
    - ENABLE_REQ = 0 → OFF, with FAULT_CODE retained.
    - ENABLE_REQ held high keeps the block in FAULT, so there is no auto-retry.
- FAULT and FAULT_CODE survive the FAULT → OFF transition for readout. They clear only on the OFF → RAMP transition or on RESET.
- Counter: a single CNT_W-bit counter, cleared on every state entry. It never wraps, because the terminal compare always exits the state.
- Timing from PG_RAW rise with ENABLE_REQ steady high:
  - SETTLE entered 2 + DEBOUNCE + 1 edges after the rise.
  - RUN entered HOLDOFF edges later.

Decomposition:
- Package pwr_supv_pkg holds:
  - State encoding localparams: OFF = 0, RAMP = 1, SETTLE = 2, RUN = 3, FAULT = 4 (3-bit).
  - FAULT_CODE constants: FC_NONE, FC_TIMEOUT, FC_BROWNOUT.
- One sub-module, pg_debounce: the synchronizer plus debounce counter, parameterised by DEBOUNCE, with ports CLK, RESET, PG_RAW, and output PG_DB.
- The FSM and counter stay in the top level.

Test Plan (DEBOUNCE = 4, RAMP_TIMEOUT = 20, HOLDOFF = 10, CNT_W = 8):
- Normal power-up: ENABLE_REQ = 1, then PG_RAW rises 5 cycles later.
  - REG_EN = 1 one edge after the request.
  - SETTLE entered 7 edges after the PG_RAW rise.
  - SYS_RESET = 0 and PWR_OK = 1 exactly 17 edges after the PG_RAW rise.
- Glitch rejection: in RUN, drive a 3-cycle low pulse on PG_RAW → PWR_OK stays 1 and FAULT stays 0 throughout.
- Ramp timeout: ENABLE_REQ = 1 with PG_RAW held at 0.
  - 20 edges after RAMP entry: FAULT = 1, FAULT_CODE = 1, REG_EN = 0.
  - Block stays in FAULT while ENABLE_REQ = 1.
  - ENABLE_REQ = 0 → OFF; FAULT_CODE is still 1.
  - ENABLE_REQ = 1 → RAMP; FAULT_CODE = 0 and FAULT = 0.
- Brown-out: in RUN, drop PG_RAW permanently.
  - pg_db falls 6 edges later.
  - FAULT = 1, FAULT_CODE = 2, SYS_RESET = 1 and REG_EN = 0 on the next edge.
- Simultaneous events: in RUN, ENABLE_REQ falls on the same edge that pg_db falls → next state is OFF, FAULT = 0, FAULT_CODE = 0.
- Asynchronous reset: assert RESET mid-SETTLE, between clock edges.
  - REG_EN = 0, SYS_RESET = 1, PWR_OK = 0 immediately.
  - After release with PG_RAW = 1 and ENABLE_REQ = 1, the full sequence restarts from OFF.
